// File: rtl/common_fifo_wr_arbiter_rr.sv
// Round-robin write arbiter in front of a single-write-port FIFO.
// Requesters present valid/ready word streams. One is granted per cycle.
// A grantee may hold the port for up to BURST_MAX consecutive words.
// Handshake: a word moves when req_valid[i] & req_ready[i] are both high
// at a clock edge. req_ready is combinational from inputs and state.
// Valid may drop at any time without penalty.
module common_fifo_wr_arbiter_rr #(
  parameter int ARB_PORTS_LOG2 = 2,
  parameter int DATA_WIDTH     = 1,
  parameter int BURST_MAX      = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [(1 << ARB_PORTS_LOG2)-1:0]           req_valid,
  input  logic [(1 << ARB_PORTS_LOG2)*DATA_WIDTH-1:0] req_data,
  output logic [(1 << ARB_PORTS_LOG2)-1:0]           req_ready,
  output logic [DATA_WIDTH-1:0]                      fifo_din,
  output logic                                       fifo_wen,
  input  logic                                       fifo_full,
  output logic                                       grant_valid,
  output logic [ARB_PORTS_LOG2-1:0]                  grant_id,
  output logic                                       dbg_state,
  output logic [ARB_PORTS_LOG2-1:0]                  dbg_prio_ptr,
  output logic [ARB_PORTS_LOG2-1:0]                  dbg_owner,
  output logic [$clog2(BURST_MAX+1)-1:0]             dbg_burst_cnt
);

  localparam int L  = ARB_PORTS_LOG2;
  localparam int N  = 1 << ARB_PORTS_LOG2;
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        state, state_n;
  logic [L-1:0]  prio_ptr, prio_ptr_n;
  logic [L-1:0]  owner, owner_n;
  logic [CW-1:0] burst_cnt, burst_cnt_n;
  logic [L-1:0]  sel, cand;
  logic          sel_valid, owner_hold, accept;

  // Pick the grantee: a still-valid lock owner wins, otherwise scan from prio_ptr.
  always_comb begin
    sel        = '0;
    sel_valid  = 1'b0;
    owner_hold = 1'b0;
    cand       = '0;
    if (state == LOCK && req_valid[owner]) begin
      sel        = owner;
      sel_valid  = 1'b1;
      owner_hold = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = prio_ptr + L'(k);
        if (!sel_valid && req_valid[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
    // Nothing is granted while reset is held.
    if (reset) begin
      sel        = '0;
      sel_valid  = 1'b0;
      owner_hold = 1'b0;
    end
  end

  assign accept = sel_valid & ~fifo_full;

  // Drive the FIFO write port and the one-hot ready from the selection.
  always_comb begin
    grant_valid = sel_valid;
    grant_id    = sel;
    fifo_wen    = accept;
    req_ready   = '0;
    fifo_din    = '0;
    if (accept) req_ready = N'(1) << sel;
    if (sel_valid) fifo_din = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state: lock/burst bookkeeping and priority rotation on accept.
  always_comb begin
    state_n     = state;
    prio_ptr_n  = prio_ptr;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    if (accept) begin
      if (owner_hold) begin
        if (burst_cnt + CW'(1) == CW'(BURST_MAX)) begin
          state_n     = IDLE;
          burst_cnt_n = '0;
        end else begin
          burst_cnt_n = burst_cnt + CW'(1);
        end
      end else begin
        // Fresh grant (from IDLE or a released lock): owner drops to lowest priority.
        prio_ptr_n = sel + L'(1);
        if (BURST_MAX > 1) begin
          state_n     = LOCK;
          owner_n     = sel;
          burst_cnt_n = CW'(1);
        end
      end
    end else if (state == LOCK && !req_valid[owner]) begin
      state_n     = IDLE;
      burst_cnt_n = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      prio_ptr  <= prio_ptr_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  assign dbg_state     = state;
  assign dbg_prio_ptr  = prio_ptr;
  assign dbg_owner     = owner;
  assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_common_fifo_wr_arbiter_rr.sv
// Directed bench for the round-robin FIFO write arbiter.
// Two instances share stimulus: one with BURST_MAX=1, one with BURST_MAX=4.
module tb_common_fifo_wr_arbiter_rr;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic          fifo_full;

  logic [3:0]    ready1, ready4;
  logic [DW-1:0] din1, din4;
  logic          wen1, wen4, gv1, gv4;
  logic [1:0]    gid1, gid4;
  logic          st1, st4;
  logic [1:0]    prio1, prio4, own1, own4;
  logic [0:0]    bc1;
  logic [2:0]    bc4;

  common_fifo_wr_arbiter_rr #(.ARB_PORTS_LOG2(2), .DATA_WIDTH(DW), .BURST_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready1), .fifo_din(din1), .fifo_wen(wen1), .fifo_full(fifo_full),
    .grant_valid(gv1), .grant_id(gid1), .dbg_state(st1), .dbg_prio_ptr(prio1),
    .dbg_owner(own1), .dbg_burst_cnt(bc1)
  );

  common_fifo_wr_arbiter_rr #(.ARB_PORTS_LOG2(2), .DATA_WIDTH(DW), .BURST_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready4), .fifo_din(din4), .fifo_wen(wen4), .fifo_full(fifo_full),
    .grant_valid(gv4), .grant_id(gid4), .dbg_state(st4), .dbg_prio_ptr(prio4),
    .dbg_owner(own4), .dbg_burst_cnt(bc4)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Word for requester i is 0xA0+i, so fifo_din identifies the source.
  function automatic logic [DW-1:0] word(input logic [1:0] i);
    return 8'hA0 + {6'd0, i};
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset state
    do_reset();
    #1;
    check("rst_state4", {31'd0, st4}, 32'd0);
    check("rst_prio4", {30'd0, prio4}, 32'd0);
    check("rst_burst4", {29'd0, bc4}, 32'd0);
    check("idle_gv4", {31'd0, gv4}, 32'd0);
    check("idle_din4", {24'd0, din4}, 32'd0);

    // 1. Per-word round-robin on BURST_MAX=1
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) exp_q.push_back(2'(c % 4));
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      #1;
      check("rr_gid", {30'd0, gid1}, {30'd0, e});
      check("rr_din", {24'd0, din1}, {24'd0, word(e)});
      check("rr_ready", {28'd0, ready1}, 32'd1 << e);
      tick();
    end

    // 2. Burst lock and rotation on BURST_MAX=4
    do_reset();
    req_valid = 4'b0110;
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      #1;
      check("burst_gid", {30'd0, gid4}, {30'd0, e});
      check("burst_wen", {31'd0, wen4}, 32'd1);
      tick();
    end

    // 3. Early release: requester 0 sends two words then drops
    do_reset();
    req_valid = 4'b1001;
    #1; check("rel_w0", {30'd0, gid4}, 32'd0);
    tick();
    #1; check("rel_w1", {30'd0, gid4}, 32'd0);
    tick();
    req_valid = 4'b1000;
    #1;
    check("rel_gid3", {30'd0, gid4}, 32'd3);
    check("rel_wen", {31'd0, wen4}, 32'd1);
    tick();
    check("rel_lock", {31'd0, st4}, 32'd1);
    check("rel_owner", {30'd0, own4}, 32'd3);
    check("rel_burst", {29'd0, bc4}, 32'd1);

    // 4. Backpressure mid-burst on owner 2
    do_reset();
    req_valid = 4'b0100;
    tick();
    tick();
    check("bp_pre_burst", {29'd0, bc4}, 32'd2);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_wen", {31'd0, wen4}, 32'd0);
      check("bp_ready", {28'd0, ready4}, 32'd0);
      check("bp_gid", {30'd0, gid4}, 32'd2);
      tick();
      check("bp_burst", {29'd0, bc4}, 32'd2);
    end
    fifo_full = 1'b0;
    req_valid = 4'b0110;
    exp_q = '{2'd2, 2'd2, 2'd1};
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      #1;
      check("bp_after_gid", {30'd0, gid4}, {30'd0, e});
      check("bp_after_wen", {31'd0, wen4}, 32'd1);
      tick();
    end

    // 5. Reset mid-burst on owner 3
    do_reset();
    req_valid = 4'b1000;
    tick();
    check("mr_owner", {30'd0, own4}, 32'd3);
    check("mr_burst", {29'd0, bc4}, 32'd1);
    req_valid = 4'b1010;
    reset     = 1'b1;
    #1;
    check("mr_wen", {31'd0, wen4}, 32'd0);
    check("mr_ready", {28'd0, ready4}, 32'd0);
    check("mr_gv", {31'd0, gv4}, 32'd0);
    check("mr_gid", {30'd0, gid4}, 32'd0);
    check("mr_din", {24'd0, din4}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mr_first_gid", {30'd0, gid4}, 32'd1);
    check("mr_first_din", {24'd0, din4}, 32'hA1);

    // 6. Sparse requests: only requester 3, BURST_MAX=1
    do_reset();
    req_valid = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("sp_gid", {30'd0, gid1}, 32'd3);
      check("sp_wen", {31'd0, wen1}, 32'd1);
      tick();
      check("sp_prio", {30'd0, prio1}, 32'd0);
    end

    // No requests: no grant, zero outputs
    req_valid = 4'b0000;
    #1;
    check("none_gv", {31'd0, gv1}, 32'd0);
    check("none_gid", {30'd0, gid1}, 32'd0);
    check("none_wen", {31'd0, wen1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
